icache: RTL and testbench

- Direct-mapped, read-only instruction cache between the fetch stage (I$ side) and the instruction memory bus.
- Fetch presents an address every cycle. The cache answers hits one cycle later at full throughput.
- On a miss it refills a whole line through a burst read, then answers the missed address.
- `flush_i` (fence.i) invalidates all lines.

---
 rtl/icache.sv | 127 ++++++++++++
 tb/tb_icache.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with whole-line burst refill.
package orion_types;
  localparam int ADDRW = 32;
  localparam int DATAW = 32;
endpackage

module icache
  import orion_types::*;
#(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [ADDRW-1:0] imem_addr_i,
  input  logic             imem_valid_i,
  output logic [DATAW-1:0] imem_rdata_o,
  output logic             imem_resp_o,
  input  logic             flush_i,
  output logic             mem_req_valid_o,
  input  logic             mem_req_ready_i,
  output logic [ADDRW-1:0] mem_addr_o,
  input  logic             mem_rvalid_i,
  input  logic [DATAW-1:0] mem_rdata_i
);
  localparam int WORDW = $clog2(LINE_WORDS);
  localparam int IDXW  = $clog2(LINES);
  localparam int OFFW  = WORDW + 2;
  localparam int TAGW  = ADDRW - OFFW - IDXW;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOOKUP    = 3'd1;
  localparam logic [2:0] S_MISS_REQ  = 3'd2;
  localparam logic [2:0] S_MISS_FILL = 3'd3;
  localparam logic [2:0] S_MISS_RESP = 3'd4;

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [ADDRW-1:0] req_addr;
  logic [WORDW-1:0] cnt;
  logic             flush_pending;
  logic [LINES-1:0] valid;
  logic [TAGW-1:0]  tag_mem  [LINES];
  logic [DATAW-1:0] data_mem [LINES][LINE_WORDS];

  logic [IDXW-1:0]  req_idx;
  logic [TAGW-1:0]  req_tag;
  logic [WORDW-1:0] req_word;
  logic             hit;
  logic             capture;
  logic             beat;
  logic             last_beat;
  logic             unused_bits;

  assign req_idx     = req_addr[OFFW +: IDXW];
  assign req_tag     = req_addr[ADDRW-1 -: TAGW];
  assign req_word    = req_addr[2 +: WORDW];
  assign unused_bits = ^req_addr[1:0];

  // A flush in the lookup cycle forces a miss so the line is re-fetched.
  assign hit       = (state == S_LOOKUP) && valid[req_idx] &&
                     (tag_mem[req_idx] == req_tag) && !flush_i;
  assign capture   = imem_valid_i &&
                     ((state == S_IDLE) || hit || (state == S_MISS_RESP));
  assign beat      = (state == S_MISS_FILL) && mem_rvalid_i;
  assign last_beat = beat && (cnt == WORDW'(LINE_WORDS - 1));

  // Next-state selection; a started miss always runs to its response.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      state_next = capture ? S_LOOKUP : S_IDLE;
      S_LOOKUP:    state_next = hit ? (capture ? S_LOOKUP : S_IDLE) : S_MISS_REQ;
      S_MISS_REQ:  state_next = mem_req_ready_i ? S_MISS_FILL : S_MISS_REQ;
      S_MISS_FILL: state_next = last_beat ? S_MISS_RESP : S_MISS_FILL;
      S_MISS_RESP: state_next = capture ? S_LOOKUP : S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  // Control state: FSM, captured address, beat counter, flush-during-miss flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      req_addr      <= '0;
      cnt           <= '0;
      flush_pending <= 1'b0;
    end else begin
      state <= state_next;
      if (capture) req_addr <= imem_addr_i;
      if ((state == S_MISS_REQ) && mem_req_ready_i) cnt <= '0;
      else if (beat)                                 cnt <= cnt + 1'b1;
      if (state == S_MISS_RESP) flush_pending <= 1'b0;
      else if (flush_i && ((state == S_MISS_REQ) || (state == S_MISS_FILL)))
        flush_pending <= 1'b1;
    end
  end

  // Valid bits: flush wins over the final refill write of the same edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                               valid <= '0;
    else if (flush_i)                        valid <= '0;
    else if (last_beat && !flush_pending)    valid[req_idx] <= 1'b1;
  end

  // Tag and data storage, written only by refill beats.
  always_ff @(posedge clk_i) begin
    if (beat)      data_mem[req_idx][cnt] <= mem_rdata_i;
    if (last_beat) tag_mem[req_idx] <= req_tag;
  end

  // Fetch response and bus request outputs; quiet in every other state.
  always_comb begin
    imem_resp_o     = 1'b0;
    imem_rdata_o    = '0;
    mem_req_valid_o = 1'b0;
    mem_addr_o      = '0;
    if (hit || (state == S_MISS_RESP)) begin
      imem_resp_o  = 1'b1;
      imem_rdata_o = data_mem[req_idx][req_word];
    end
    if (state == S_MISS_REQ) begin
      mem_req_valid_o = 1'b1;
      mem_addr_o      = {req_addr[ADDRW-1:OFFW], {OFFW{1'b0}}};
    end
  end
endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed fetch sequences against a cache-content model.
`timescale 1ns/1ps
module tb_icache;
  localparam int LINES = 64;
  localparam int LW    = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] imem_addr_i;
  logic        imem_valid_i;
  logic [31:0] imem_rdata_o;
  logic        imem_resp_o;
  logic        flush_i;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i = 1'b0;
  logic [31:0] mem_addr_o;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'hdead_beef;

  icache #(.LINES(LINES), .LINE_WORDS(LW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .imem_addr_i(imem_addr_i), .imem_valid_i(imem_valid_i),
    .imem_rdata_o(imem_rdata_o), .imem_resp_o(imem_resp_o),
    .flush_i(flush_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Backing memory contents seen by the cache.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'd32) + 32'h13;
  endfunction

  // Cache-content model: which line base each index holds.
  bit          m_valid [LINES];
  logic [31:0] m_tag   [LINES];
  function automatic void model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endfunction
  function automatic bit model_access(input logic [31:0] a);
    int          i = int'((a / (LW * 4)) % LINES);
    logic [31:0] t = a / (LW * 4 * LINES);
    if (m_valid[i] && m_tag[i] == t) return 1'b1;
    m_valid[i] = 1'b1;
    m_tag[i]   = t;
    return 1'b0;
  endfunction

  // Bus stall configuration shared by the responder and the latency model.
  int rd  = 0;
  int gap = 0;
  function automatic int miss_lat();
    return 3 + LW + rd + (LW - 1) * gap;
  endfunction

  typedef struct { logic [31:0] addr; bit miss; int due; } exp_t;
  typedef struct { logic [31:0] data; int c; } log_t;
  exp_t expq[$];
  log_t rlog[$];
  int   caps[$];
  exp_t e;

  // Compare process: every cycle, outputs against the scoreboard.
  always @(negedge clk) begin
    if (rst_i) begin
      chk("rst_resp",  {31'd0, imem_resp_o}, 32'd0);
      chk("rst_rdata", imem_rdata_o, 32'd0);
      chk("rst_req",   {31'd0, mem_req_valid_o}, 32'd0);
      chk("rst_maddr", mem_addr_o, 32'd0);
    end else begin
      if (imem_resp_o) begin
        rlog.push_back('{imem_rdata_o, cyc});
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: got resp=1 at cycle %0d, required none", cyc);
        end else begin
          e = expq.pop_front();
          chk("resp_data", imem_rdata_o, mem_word(e.addr));
          chk("resp_cycle", cyc, e.due);
        end
      end else begin
        chk("quiet_rdata", imem_rdata_o, 32'd0);
        if (expq.size() > 0 && cyc > expq[0].due) begin
          chk("resp_late", cyc, expq[0].due);
          void'(expq.pop_front());
        end
      end
      if (mem_req_valid_o) begin
        if (expq.size() > 0 && expq[0].miss)
          chk("req_addr", mem_addr_o, expq[0].addr & ~32'(LW * 4 - 1));
        else begin
          checks++; errors++;
          $display("FAIL spurious_req: got request for %h, required no request", mem_addr_o);
        end
      end else
        chk("idle_maddr", mem_addr_o, 32'd0);
    end
  end

  // Bus responder: waits rd cycles before ready, then LW beats separated by gap idle cycles.
  int          bus_ph = 0, bus_w = 0, bus_i = 0, bus_g = 0;
  logic [31:0] bus_base;
  int          req_cycles = 0, req_total = 0, beats_sent = 0;
  always @(negedge clk) begin
    mem_rvalid_i    = 1'b0;
    mem_req_ready_i = 1'b0;
    mem_rdata_i     = 32'hdead_beef;
    if (rst_i) bus_ph = 0;
    else begin
      if (mem_req_valid_o) req_total++;
      case (bus_ph)
        0: if (mem_req_valid_o) begin
             bus_base   = mem_addr_o;
             req_cycles = 1;
             bus_i = 0; bus_g = 0;
             if (rd == 0) begin mem_req_ready_i = 1'b1; bus_ph = 2; end
             else begin bus_w = 1; bus_ph = 1; end
           end
        1: begin
             req_cycles++;
             if (bus_w == rd) begin mem_req_ready_i = 1'b1; bus_ph = 2; end
             else bus_w++;
           end
        default: begin
             if (bus_i > 0 && bus_g < gap) bus_g++;
             else begin
               mem_rvalid_i = 1'b1;
               mem_rdata_i  = mem_word(bus_base + 32'(4 * bus_i));
               bus_i++;
               bus_g = 0;
               beats_sent = bus_i;
               if (bus_i == LW) bus_ph = 0;
             end
           end
      endcase
    end
  end

  function automatic logic [31:0] rdat(input int i);
    return (i < rlog.size()) ? rlog[i].data : 32'hffff_ffff;
  endfunction
  function automatic int rcyc(input int i);
    return (i < rlog.size()) ? rlog[i].c : -1000;
  endfunction
  function automatic int capc(input int i);
    return (i < caps.size()) ? caps[i] : -2000;
  endfunction

  logic [31:0] seq[$];
  int          hold_prev = 0;

  task automatic capture(input logic [31:0] a);
    bit h = model_access(a);
    caps.push_back(cyc);
    expq.push_back('{a, !h, cyc + (h ? 1 : miss_lat())});
  endtask

  // Fetch side: hold each address until a response shows it was captured.
  task automatic run_seq();
    bit got;
    rlog.delete();
    caps.delete();
    @(posedge clk); #1;
    imem_valid_i = 1'b1;
    imem_addr_i  = seq[0];
    capture(seq[0]);
    @(posedge clk); #1;
    for (int k = 1; k < seq.size(); k++) begin
      got = 1'b0;
      imem_addr_i = (hold_prev > 0) ? seq[k-1] : seq[k];
      for (int w = 0; w < 200 && !got; w++) begin
        if (w == hold_prev) imem_addr_i = seq[k];
        @(negedge clk); #1;
        if (imem_resp_o) got = 1'b1;
        else begin @(posedge clk); #1; end
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL seq_wait: got no response in 200 cycles, required one");
        break;
      end
      capture(seq[k]);
      @(posedge clk); #1;
    end
    imem_valid_i = 1'b0;
    for (int w = 0; expq.size() > 0; w++) begin
      @(negedge clk); #1;
      if (w > 200) begin
        checks++; errors++;
        $display("FAIL drain: got %0d responses outstanding, required 0", expq.size());
        expq.delete();
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by time limit, required finish");
    $fatal(1);
  end

  int base;
  initial begin
    rst_i = 1'b1; imem_valid_i = 1'b0; imem_addr_i = '0; flush_i = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    // Cold miss
    seq = {32'h8000_0000}; run_seq();
    chk("cold_data", rdat(0), 32'h13);
    chk("cold_latency", rcyc(0) - capc(0), 7);
    chk("cold_req_cycles", req_cycles, 1);

    // Streaming hits
    base = req_total;
    seq = {32'h8000_0004, 32'h8000_0008, 32'h8000_000c}; run_seq();
    chk("stream_d0", rdat(0), 32'h93);
    chk("stream_d1", rdat(1), 32'h113);
    chk("stream_d2", rdat(2), 32'h193);
    chk("stream_first_lat", rcyc(0) - capc(0), 1);
    chk("stream_span", rcyc(2) - rcyc(0), 2);
    chk("stream_no_req", req_total - base, 0);

    // Redirect during miss: new address presented mid-fill
    hold_prev = 3;
    seq = {32'h8000_0010, 32'h8000_0000}; run_seq();
    hold_prev = 0;
    chk("redir_d0", rdat(0), 32'h213);
    chk("redir_d1", rdat(1), 32'h13);
    chk("redir_hit_gap", rcyc(1) - rcyc(0), 1);

    // Conflict eviction on index 0
    seq = {32'h8000_0400, 32'h8000_0000}; run_seq();
    chk("evict_d0", rdat(0), 32'h8013);
    chk("evict_lat0", rcyc(0) - capc(0), 7);
    chk("evict_lat1", rcyc(1) - rcyc(0), 7);

    // Flush while idle
    @(posedge clk); #1 flush_i = 1'b1; model_reset();
    @(posedge clk); #1 flush_i = 1'b0;
    seq = {32'h8000_0000}; run_seq();
    chk("flush_idle_lat", rcyc(0) - capc(0), 7);

    // Flush during refill: response delivered, line stays invalid
    seq = {32'h8000_0020};
    fork
      run_seq();
      begin
        @(posedge clk); #1;
        repeat (4) begin @(posedge clk); #1; end
        flush_i = 1'b1; model_reset();
        @(posedge clk); #1 flush_i = 1'b0;
      end
    join
    chk("flush_fill_data", rdat(0), 32'h413);
    seq = {32'h8000_0020}; run_seq();
    chk("flush_fill_remiss", rcyc(0) - capc(0), 7);

    // Flush coinciding with a hit in lookup: refetched, then valid
    model_reset();
    seq = {32'h8000_0020};
    fork
      run_seq();
      begin
        @(posedge clk); #1;
        @(posedge clk); #1 flush_i = 1'b1;
        @(posedge clk); #1 flush_i = 1'b0;
      end
    join
    chk("flush_hit_lat", rcyc(0) - capc(0), 7);
    seq = {32'h8000_0020}; run_seq();
    chk("flush_hit_after", rcyc(0) - capc(0), 1);

    // Bus stalls: 3 ready-low cycles and 1-cycle beat gaps
    rd = 3; gap = 1;
    seq = {32'h8000_0030}; run_seq();
    chk("stall_data", rdat(0), 32'h613);
    chk("stall_latency", rcyc(0) - capc(0), 13);
    chk("stall_req_cycles", req_cycles, 4);
    rd = 0; gap = 0;

    // Reset after two refill beats
    beats_sent = 0;
    @(posedge clk); #1;
    imem_valid_i = 1'b1; imem_addr_i = 32'h8000_0040;
    capture(32'h8000_0040);
    @(posedge clk); #1 imem_valid_i = 1'b0;
    for (int w = 0; w < 50 && beats_sent < 2; w++) begin @(negedge clk); #1; end
    chk("rst_beats_seen", beats_sent, 2);
    @(posedge clk); #1;
    rst_i = 1'b1;
    expq.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    seq = {32'h8000_0040}; run_seq();
    chk("rst_remiss_lat", rcyc(0) - capc(0), 7);
    chk("rst_remiss_data", rdat(0), 32'h813);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
